// File: rtl/axi_demux_1to2_if.sv
// AXI-style bus bundle shared by the 1:2 demux and its neighbours.
// Master drives AW/W/AR and the B/R readies; slave drives the rest.
interface axi_interface #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    logic [31:0]           awaddr;
    logic [LEN_WIDTH-1:0]  awlen;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [31:0]           araddr;
    logic [LEN_WIDTH-1:0]  arlen;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awlen, awvalid,
        input  awready,
        output wdata, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awvalid,
        output awready,
        input  wdata, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_demux_1to2.sv
// Steers one AXI master to one of two targets, one transaction at a time.
// Addresses at or above DEC_LIMIT are answered locally with DECERR.
module axi_demux_1to2 #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] DEC_LIMIT  = 32'hFFFF_FFFF,
    parameter int          LEN_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    axi_interface.slave  axi_bus_s,
    axi_interface.master axi_bus_m0,
    axi_interface.master axi_bus_m1,
    output logic        busy
);
    typedef enum logic [2:0] {
        IDLE, WR_A, WR_D, WR_B, RD_A, RD_D
    } state_t;

    state_t               state;
    state_t               state_d;
    logic                 tgt;
    logic                 err;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] beat_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tgt      <= 1'b0;
            err      <= 1'b0;
            len_q    <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE) begin
                if (axi_bus_s.awvalid) begin
                    tgt <= sel;
                    err <= (axi_bus_s.awaddr >= DEC_LIMIT);
                end else if (axi_bus_s.arvalid) begin
                    tgt <= sel;
                    err <= (axi_bus_s.araddr >= DEC_LIMIT);
                end
            end
            if (state == RD_A && err)
                len_q <= axi_bus_s.arlen;
            if (state == RD_D && state_d != RD_D)
                beat_cnt <= '0;
            else if (state == RD_D && err &&
                     axi_bus_s.rvalid && axi_bus_s.rready)
                beat_cnt <= beat_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (axi_bus_s.awvalid)
                    state_d = WR_A;
                else if (axi_bus_s.arvalid)
                    state_d = RD_A;
            end
            WR_A: if (axi_bus_s.awvalid && axi_bus_s.awready)
                state_d = WR_D;
            WR_D: if (axi_bus_s.wvalid && axi_bus_s.wready &&
                      axi_bus_s.wlast)
                state_d = WR_B;
            WR_B: if (axi_bus_s.bvalid && axi_bus_s.bready)
                state_d = IDLE;
            RD_A: if (axi_bus_s.arvalid && axi_bus_s.arready)
                state_d = RD_D;
            RD_D: if (axi_bus_s.rvalid && axi_bus_s.rready &&
                      axi_bus_s.rlast)
                state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Everything defaults to zero; only the active channel of the
    // latched target (or the local responder) is opened up.
    always_comb begin
        busy = (state != IDLE);
        axi_bus_s.awready = 1'b0;
        axi_bus_s.wready  = 1'b0;
        axi_bus_s.bvalid  = 1'b0;
        axi_bus_s.bresp   = 2'b00;
        axi_bus_s.arready = 1'b0;
        axi_bus_s.rvalid  = 1'b0;
        axi_bus_s.rdata   = '0;
        axi_bus_s.rresp   = 2'b00;
        axi_bus_s.rlast   = 1'b0;
        axi_bus_m0.awaddr  = '0;
        axi_bus_m0.awlen   = '0;
        axi_bus_m0.awvalid = 1'b0;
        axi_bus_m0.wdata   = '0;
        axi_bus_m0.wlast   = 1'b0;
        axi_bus_m0.wvalid  = 1'b0;
        axi_bus_m0.bready  = 1'b0;
        axi_bus_m0.araddr  = '0;
        axi_bus_m0.arlen   = '0;
        axi_bus_m0.arvalid = 1'b0;
        axi_bus_m0.rready  = 1'b0;
        axi_bus_m1.awaddr  = '0;
        axi_bus_m1.awlen   = '0;
        axi_bus_m1.awvalid = 1'b0;
        axi_bus_m1.wdata   = '0;
        axi_bus_m1.wlast   = 1'b0;
        axi_bus_m1.wvalid  = 1'b0;
        axi_bus_m1.bready  = 1'b0;
        axi_bus_m1.araddr  = '0;
        axi_bus_m1.arlen   = '0;
        axi_bus_m1.arvalid = 1'b0;
        axi_bus_m1.rready  = 1'b0;
        unique case (state)
            WR_A: begin
                if (err) begin
                    axi_bus_s.awready = 1'b1;
                end else if (tgt) begin
                    axi_bus_m1.awaddr  = axi_bus_s.awaddr;
                    axi_bus_m1.awlen   = axi_bus_s.awlen;
                    axi_bus_m1.awvalid = axi_bus_s.awvalid;
                    axi_bus_s.awready  = axi_bus_m1.awready;
                end else begin
                    axi_bus_m0.awaddr  = axi_bus_s.awaddr;
                    axi_bus_m0.awlen   = axi_bus_s.awlen;
                    axi_bus_m0.awvalid = axi_bus_s.awvalid;
                    axi_bus_s.awready  = axi_bus_m0.awready;
                end
            end
            WR_D: begin
                if (err) begin
                    axi_bus_s.wready = 1'b1;
                end else if (tgt) begin
                    axi_bus_m1.wdata  = axi_bus_s.wdata;
                    axi_bus_m1.wlast  = axi_bus_s.wlast;
                    axi_bus_m1.wvalid = axi_bus_s.wvalid;
                    axi_bus_s.wready  = axi_bus_m1.wready;
                end else begin
                    axi_bus_m0.wdata  = axi_bus_s.wdata;
                    axi_bus_m0.wlast  = axi_bus_s.wlast;
                    axi_bus_m0.wvalid = axi_bus_s.wvalid;
                    axi_bus_s.wready  = axi_bus_m0.wready;
                end
            end
            WR_B: begin
                if (err) begin
                    axi_bus_s.bvalid = 1'b1;
                    axi_bus_s.bresp  = 2'b11;
                end else if (tgt) begin
                    axi_bus_s.bvalid  = axi_bus_m1.bvalid;
                    axi_bus_s.bresp   = axi_bus_m1.bresp;
                    axi_bus_m1.bready = axi_bus_s.bready;
                end else begin
                    axi_bus_s.bvalid  = axi_bus_m0.bvalid;
                    axi_bus_s.bresp   = axi_bus_m0.bresp;
                    axi_bus_m0.bready = axi_bus_s.bready;
                end
            end
            RD_A: begin
                if (err) begin
                    axi_bus_s.arready = 1'b1;
                end else if (tgt) begin
                    axi_bus_m1.araddr  = axi_bus_s.araddr;
                    axi_bus_m1.arlen   = axi_bus_s.arlen;
                    axi_bus_m1.arvalid = axi_bus_s.arvalid;
                    axi_bus_s.arready  = axi_bus_m1.arready;
                end else begin
                    axi_bus_m0.araddr  = axi_bus_s.araddr;
                    axi_bus_m0.arlen   = axi_bus_s.arlen;
                    axi_bus_m0.arvalid = axi_bus_s.arvalid;
                    axi_bus_s.arready  = axi_bus_m0.arready;
                end
            end
            RD_D: begin
                if (err) begin
                    axi_bus_s.rvalid = 1'b1;
                    axi_bus_s.rdata  = {DATA_WIDTH{1'b0}};
                    axi_bus_s.rresp  = 2'b11;
                    axi_bus_s.rlast  = (beat_cnt == len_q);
                end else if (tgt) begin
                    axi_bus_s.rvalid  = axi_bus_m1.rvalid;
                    axi_bus_s.rdata   = axi_bus_m1.rdata;
                    axi_bus_s.rresp   = axi_bus_m1.rresp;
                    axi_bus_s.rlast   = axi_bus_m1.rlast;
                    axi_bus_m1.rready = axi_bus_s.rready;
                end else begin
                    axi_bus_s.rvalid  = axi_bus_m0.rvalid;
                    axi_bus_s.rdata   = axi_bus_m0.rdata;
                    axi_bus_s.rresp   = axi_bus_m0.rresp;
                    axi_bus_s.rlast   = axi_bus_m0.rlast;
                    axi_bus_m0.rready = axi_bus_s.rready;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axi_demux_1to2.sv
// Directed bench for axi_demux_1to2: vector table plus hand sequences.
// Two target models answer with distinct resp codes and data tags.
module tb_axi_demux_1to2;
    localparam int TMO = 50;

    bit   clk = 1'b0;
    logic reset;
    logic sel;
    logic busy;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    axi_interface #(.DATA_WIDTH(32), .LEN_WIDTH(8)) s ();
    axi_interface #(.DATA_WIDTH(32), .LEN_WIDTH(8)) m [2] ();

    axi_demux_1to2 #(
        .DATA_WIDTH(32), .DEC_LIMIT(32'hFFFF_FFFF), .LEN_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel),
        .axi_bus_s(s), .axi_bus_m0(m[0]), .axi_bus_m1(m[1]),
        .busy(busy)
    );

    // Target g: always ready on AW/W/AR, bresp/rresp = g, rdata tagged.
    for (genvar g = 0; g < 2; g++) begin : tg
        int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
        int ar_cnt = 0, r_cnt = 0, vld_cyc = 0;
        int rbeat = 0, rlen = 0;
        logic [31:0] last_awaddr = '0, last_wdata = '0;
        logic [31:0] last_araddr = '0;
        logic [59:0] snap;
        assign snap = {10'(aw_cnt), 10'(w_cnt), 10'(b_cnt),
                       10'(ar_cnt), 10'(r_cnt), 10'(vld_cyc)};
        initial begin
            bit aw_h, wl_h, b_h, ar_h, r_h, rl_h, rs;
            int al;
            m[g].awready = 1'b1;
            m[g].wready  = 1'b1;
            m[g].arready = 1'b1;
            m[g].bvalid  = 1'b0;
            m[g].bresp   = 2'b00;
            m[g].rvalid  = 1'b0;
            m[g].rdata   = '0;
            m[g].rresp   = 2'b00;
            m[g].rlast   = 1'b0;
            forever begin
                @(negedge clk);
                rs   = reset;
                aw_h = m[g].awvalid && m[g].awready;
                ar_h = m[g].arvalid && m[g].arready;
                b_h  = m[g].bvalid && m[g].bready;
                r_h  = m[g].rvalid && m[g].rready;
                rl_h = r_h && m[g].rlast;
                wl_h = m[g].wvalid && m[g].wready && m[g].wlast;
                al   = int'(m[g].arlen);
                if (aw_h) begin aw_cnt++; last_awaddr = m[g].awaddr; end
                if (m[g].wvalid && m[g].wready) begin
                    w_cnt++;
                    last_wdata = m[g].wdata;
                end
                if (b_h) b_cnt++;
                if (ar_h) begin ar_cnt++; last_araddr = m[g].araddr; end
                if (r_h) r_cnt++;
                if (m[g].awvalid || m[g].wvalid || m[g].arvalid)
                    vld_cyc++;
                @(posedge clk);
                #1;
                if (rs) begin
                    m[g].bvalid = 1'b0;
                    m[g].rvalid = 1'b0;
                    m[g].rlast  = 1'b0;
                end else begin
                    if (b_h) m[g].bvalid = 1'b0;
                    if (wl_h) begin
                        m[g].bvalid = 1'b1;
                        m[g].bresp  = 2'(g);
                    end
                    if (rl_h) begin
                        m[g].rvalid = 1'b0;
                        m[g].rlast  = 1'b0;
                    end else if (r_h) begin
                        rbeat++;
                        m[g].rdata = 32'hA000_0000 | (32'(g) << 24) | 32'(rbeat);
                        m[g].rlast = (rbeat == rlen);
                    end
                    if (ar_h) begin
                        rlen  = al;
                        rbeat = 0;
                        m[g].rvalid = 1'b1;
                        m[g].rresp  = 2'(g);
                        m[g].rdata  = 32'hA000_0000 | (32'(g) << 24);
                        m[g].rlast  = (al == 0);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {s.awready, s.wready, s.bvalid, s.arready, s.rvalid,
                s.rlast, s.bresp, s.rresp, s.rdata,
                m[0].awvalid, m[0].wvalid, m[0].arvalid,
                m[0].bready, m[0].rready,
                m[1].awvalid, m[1].wvalid, m[1].arvalid,
                m[1].bready, m[1].rready};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input int k, input string nm);
        int n = 0;
        bit ok = 1'b0;
        do begin
            @(negedge clk);
            n++;
            case (k)
                0: ok = s.awready;
                1: ok = s.wready;
                2: ok = s.bvalid;
                3: ok = s.arready;
                default: ok = s.rvalid;
            endcase
        end while (!ok && n < TMO);
        chk(nm, 64'(ok), 64'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input int len,
                            input bit sl, input int et,
                            input logic [1:0] eresp);
        s.awaddr = addr;
        s.awlen = 8'(len);
        s.awvalid = 1'b1;
        sel = sl;
        @(negedge clk);
        chk("aw_idle_ready", 64'(s.awready), 64'd0);
        chk("aw_idle_busy", 64'(busy), 64'd0);
        wait_rdy(0, "aw_timeout");
        chk("aw_route", {m[1].awvalid, m[0].awvalid},
            (et == 0) ? 64'b01 : (et == 1) ? 64'b10 : 64'b00);
        step();
        s.awvalid = 1'b0;
        sel = ~sl;
        for (int i = 0; i <= len; i++) begin
            s.wdata = 32'hD000_0000 + 32'(i);
            s.wlast = (i == len);
            s.wvalid = 1'b1;
            wait_rdy(1, "w_timeout");
            step();
        end
        s.wvalid = 1'b0;
        s.wlast = 1'b0;
        s.bready = 1'b1;
        wait_rdy(2, "b_timeout");
        chk("bresp", 64'(s.bresp), 64'(eresp));
        step();
        s.bready = 1'b0;
        @(negedge clk);
        chk("busy_after_b", 64'(busy), 64'd0);
        step();
    endtask

    task automatic do_read(input logic [31:0] addr, input int len,
                           input bit sl, input int et,
                           input logic [1:0] eresp, input int stall,
                           input bit chk_lat);
        logic [31:0] ed;
        s.araddr = addr;
        s.arlen = 8'(len);
        s.arvalid = 1'b1;
        sel = sl;
        if (chk_lat) begin
            @(negedge clk);
            chk("ar_idle_ready", 64'(s.arready), 64'd0);
            chk("ar_idle_busy", 64'(busy), 64'd0);
        end
        wait_rdy(3, "ar_timeout");
        chk("ar_route", {m[1].arvalid, m[0].arvalid},
            (et == 0) ? 64'b01 : (et == 1) ? 64'b10 : 64'b00);
        step();
        s.arvalid = 1'b0;
        sel = ~sl;
        s.rready = 1'b1;
        for (int i = 0; i <= len; i++) begin
            if (i == stall) begin
                s.rready = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("stall_rready", {m[1].rready, m[0].rready}, 64'd0);
                    chk("stall_rvalid", 64'(s.rvalid), 64'd1);
                    step();
                end
                s.rready = 1'b1;
            end
            wait_rdy(4, "r_timeout");
            ed = (et == 2) ? 32'd0 :
                 (32'hA000_0000 | (32'(et) << 24) | 32'(i));
            chk("rbeat", {s.rdata, s.rresp, s.rlast},
                {ed, eresp, (i == len)});
            step();
        end
        s.rready = 1'b0;
        @(negedge clk);
        chk("busy_after_r", 64'(busy), 64'd0);
        step();
    endtask

    task automatic chk_counts(input bit wr, input int len, input int et,
                              input logic [59:0] b0, input logic [59:0] b1);
        logic [59:0] d0, d1, e;
        d0 = tg[0].snap - b0;
        d1 = tg[1].snap - b1;
        e = wr ? {10'd1, 10'(len + 1), 10'd1, 30'd0}
               : {30'd0, 10'd1, 10'(len + 1), 10'd0};
        chk("cnt_m0", 64'(d0[59:10]), (et == 0) ? 64'(e[59:10]) : 64'd0);
        chk("cnt_m1", 64'(d1[59:10]), (et == 1) ? 64'(e[59:10]) : 64'd0);
        chk("vld_idle_tgt",
            (et == 0) ? 64'(d1[9:0]) : (et == 1) ? 64'(d0[9:0])
                      : 64'({d1[9:0], d0[9:0]}), 64'd0);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        bit          sl;
        int          len;
        int          et;
        logic [1:0]  resp;
        int          stall;
    } vec_t;

    vec_t vt [9];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [59:0] b0, b1;
        vt[0] = '{1'b1, 32'h0000_0100, 1'b0, 0,   0, 2'b00, -1};
        vt[1] = '{1'b0, 32'h2000_0000, 1'b1, 3,   1, 2'b01, 2};
        vt[2] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 2,   2, 2'b11, -1};
        vt[3] = '{1'b0, 32'hFFFF_FFFF, 1'b0, 1,   2, 2'b11, -1};
        vt[4] = '{1'b1, 32'h1000_0000, 1'b1, 3,   1, 2'b01, -1};
        vt[5] = '{1'b0, 32'h0FFF_FFFC, 1'b0, 0,   0, 2'b00, -1};
        vt[6] = '{1'b0, 32'hFFFF_FFFE, 1'b1, 2,   1, 2'b01, 0};
        vt[7] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 0,   2, 2'b11, -1};
        vt[8] = '{1'b0, 32'hFFFF_FFFF, 1'b1, 255, 2, 2'b11, 200};

        reset = 1'b1;
        sel = 1'b0;
        s.awaddr = '0; s.awlen = '0; s.awvalid = 1'b0;
        s.wdata = '0; s.wlast = 1'b0; s.wvalid = 1'b0;
        s.bready = 1'b0;
        s.araddr = '0; s.arlen = '0; s.arvalid = 1'b0;
        s.rready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_outs", outs(), 64'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("idle_outs", outs(), 64'd0);
        step();

        for (int i = 0; i < 9; i++) begin
            b0 = tg[0].snap;
            b1 = tg[1].snap;
            if (vt[i].wr)
                do_write(vt[i].addr, vt[i].len, vt[i].sl,
                         vt[i].et, vt[i].resp);
            else
                do_read(vt[i].addr, vt[i].len, vt[i].sl,
                        vt[i].et, vt[i].resp, vt[i].stall, 1'b1);
            chk_counts(vt[i].wr, vt[i].len, vt[i].et, b0, b1);
            if (vt[i].et < 2 && vt[i].wr) begin
                chk("awaddr_fwd", (vt[i].et == 1) ? tg[1].last_awaddr
                                                  : tg[0].last_awaddr,
                    64'(vt[i].addr));
                chk("wdata_fwd", (vt[i].et == 1) ? tg[1].last_wdata
                                                 : tg[0].last_wdata,
                    64'(32'hD000_0000 + 32'(vt[i].len)));
            end else if (vt[i].et < 2) begin
                chk("araddr_fwd", (vt[i].et == 1) ? tg[1].last_araddr
                                                  : tg[0].last_araddr,
                    64'(vt[i].addr));
            end
        end

        // Simultaneous AW and AR: write runs to completion first.
        b0 = tg[0].snap;
        b1 = tg[1].snap;
        s.araddr = 32'h2000_0000;
        s.arlen = 8'd0;
        s.arvalid = 1'b1;
        do_write(32'h0000_0200, 1, 1'b0, 0, 2'b00);
        chk_counts(1'b1, 1, 0, b0, b1);
        b0 = tg[0].snap;
        b1 = tg[1].snap;
        do_read(32'h2000_0000, 0, 1'b1, 1, 2'b01, -1, 1'b0);
        chk_counts(1'b0, 0, 1, b0, b1);

        // Reset in WR_D after the first of four W beats.
        s.awaddr = 32'h0000_0300;
        s.awlen = 8'd3;
        s.awvalid = 1'b1;
        sel = 1'b0;
        wait_rdy(0, "rst_aw_timeout");
        step();
        s.awvalid = 1'b0;
        s.wdata = 32'h5555_0000;
        s.wlast = 1'b0;
        s.wvalid = 1'b1;
        wait_rdy(1, "rst_w_timeout");
        step();
        reset = 1'b1;
        s.wvalid = 1'b0;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_outs", outs(), 64'd0);
        s.bready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_b", {s.bvalid, busy}, 64'd0);
        end
        step();
        s.bready = 1'b0;
        b0 = tg[0].snap;
        b1 = tg[1].snap;
        do_write(32'h1000_0040, 1, 1'b1, 1, 2'b01);
        chk_counts(1'b1, 1, 1, b0, b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
